// File: rtl/clk_div_monitor.sv
// Receive-side monitor for a divided clock: synchronizes it, produces edge ticks,
// measures period/high time in clk_in cycles and reports lock and loss of signal.
module clk_div_monitor #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [MC_W-1:0]  match_inc_s;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             active_s, is_match_s, saturated_s;

  // Absolute difference compared without relying on signed wrap-around.
  function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= TOL_V);
  endfunction

  assign active_s    = (state_q == ST_ARM) || (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
  assign is_match_s  = within_tol(period_cnt_q, prev_q);
  assign saturated_s = (period_cnt_q == CNT_MAX);
  assign match_inc_s = match_cnt_q + MC_ONE;

  always_comb begin
    state_d        = state_q;
    period_cnt_d   = period_cnt_q;
    high_cnt_d     = high_cnt_q;
    prev_d         = prev_q;
    match_cnt_d    = match_cnt_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;

    // Counters sit still while idle or lost, but a rise always restarts them.
    if (rise_q) begin
      period_cnt_d = CNT_ONE;
      high_cnt_d   = CNT_ONE;
    end else if (active_s) begin
      period_cnt_d = saturated_s ? period_cnt_q : (period_cnt_q + CNT_ONE);
      high_cnt_d   = (high_cnt_q == CNT_MAX) ? high_cnt_q : (high_cnt_q + CNT_ONE);
    end else begin
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
    end

    if (fall_q && active_s) begin
      high_time_d = high_cnt_q;
    end else begin
      high_time_d = high_time_q;
    end

    if (rise_q && active_s) begin
      period_d       = period_cnt_q;
      period_valid_d = 1'b1;
      prev_d         = period_cnt_q;
    end else begin
      period_valid_d = 1'b0;
    end

    // A rise in the saturation cycle wins, so a late edge never enters LOST.
    case (state_q)
      ST_IDLE: begin
        if (rise_q) state_d = ST_ARM;
        else        state_d = ST_IDLE;
      end
      ST_ARM: begin
        if (rise_q) begin
          match_cnt_d = '0;
          state_d     = ST_MEASURE;
        end else if (saturated_s) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_MEASURE: begin
        if (rise_q) begin
          if (is_match_s) begin
            match_cnt_d = match_inc_s;
            if (match_inc_s >= MC_LOCK) state_d = ST_LOCKED;
            else                        state_d = ST_MEASURE;
          end else begin
            match_cnt_d = '0;
          end
        end else if (saturated_s) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (rise_q) begin
          if (!is_match_s) begin
            match_cnt_d = '0;
            state_d     = ST_MEASURE;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (saturated_s) begin
          state_d = ST_LOST;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOST: begin
        if (rise_q) state_d = ST_ARM;
        else        state_d = ST_LOST;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    locked_d  = (state_d == ST_LOCKED);
    timeout_d = (state_d == ST_LOST);
  end

  // Synchronizer, edge detect, measurement state and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      state_q        <= ST_IDLE;
      period_cnt_q   <= '0;
      high_cnt_q     <= '0;
      prev_q         <= '0;
      match_cnt_q    <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      s1_q           <= div_clk_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      rise_q         <= s2_q & ~s3_q;
      fall_q         <= ~s2_q & s3_q;
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      high_cnt_q     <= high_cnt_d;
      prev_q         <= prev_d;
      match_cnt_q    <= match_cnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  assign rise_tick    = rise_q;
  assign fall_tick    = fall_q;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: an event/timestamp-level model of the
// monitor is compared against the DUT every cycle, plus hand-computed pins.
module tb_clk_div_monitor;

  localparam int CW   = 8;
  localparam int LC   = 4;
  localparam int TL   = 1;
  localparam int MAXV = 255;
  localparam int HN   = 8192;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          div_clk_in = 1'b0;
  logic          rise_tick, fall_tick, period_valid, locked, timeout;
  logic [CW-1:0] period, high_time;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_monitor #(.CNT_W(CW), .LOCK_COUNT(LC), .TOL(TL)) dut (
    .clk_in(clk_in), .rst(rst), .div_clk_in(div_clk_in),
    .rise_tick(rise_tick), .fall_tick(fall_tick),
    .period(period), .high_time(high_time),
    .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  // Model: input history per edge, expected tick per cycle, and timestamp-based
  // measurement (count = cycles since the last rise event, clipped at MAXV).
  int cyc = 3;
  bit hist [0:HN-1];
  int phase = 0;          // 0 waiting, 1 armed, 2 measuring, 3 lost
  bit m_locked = 1'b0;
  int m_run = 0, m_prev = 0, m_period = 0, m_high = 0, m_last_rise = 0;
  bit m_valid = 1'b0, m_rise = 1'b0, m_fall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk_in) begin : model
    bit r_ev, f_ev, match;
    int pc, d;
    r_ev = m_rise;
    f_ev = m_fall;
    cyc  = cyc + 1;
    if (cyc >= HN) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HN);
      $fatal(1, "cycle budget exceeded");
    end
    if (rst) begin
      hist[cyc] = 1'b0; hist[cyc-1] = 1'b0; hist[cyc-2] = 1'b0;
      phase = 0; m_locked = 1'b0; m_run = 0; m_prev = 0;
      m_period = 0; m_high = 0; m_valid = 1'b0; m_last_rise = cyc;
      m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      hist[cyc] = div_clk_in;
      pc = (cyc - 1) - m_last_rise;
      if (pc > MAXV) pc = MAXV;
      m_valid = 1'b0;
      if (f_ev && (phase == 1 || phase == 2)) m_high = pc;
      if (r_ev) begin
        if (phase == 0 || phase == 3) begin
          phase = 1;
        end else if (phase == 1) begin
          m_period = pc; m_valid = 1'b1; m_prev = pc; m_run = 0; phase = 2;
        end else begin
          m_period = pc; m_valid = 1'b1;
          d = (pc > m_prev) ? pc - m_prev : m_prev - pc;
          match = (d <= TL);
          m_prev = pc;
          if (m_locked) begin
            if (!match) begin m_locked = 1'b0; m_run = 0; end
          end else if (match) begin
            m_run++;
            if (m_run >= LC) m_locked = 1'b1;
          end else begin
            m_run = 0;
          end
        end
        m_last_rise = cyc - 1;
      end else if ((phase == 1 || phase == 2) && pc == MAXV) begin
        phase = 3;
        m_locked = 1'b0;
      end
      m_rise = hist[cyc-2] & ~hist[cyc-3];
      m_fall = ~hist[cyc-2] & hist[cyc-3];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (cyc >= 4) begin
      chk("rise_tick", rise_tick, m_rise);
      chk("fall_tick", fall_tick, m_fall);
      chk("period", period, m_period);
      chk("high_time", high_time, m_high);
      chk("period_valid", period_valid, m_valid);
      chk("locked", locked, m_locked);
      chk("timeout", timeout, phase == 3);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      div_clk_in = 1'b1;
      repeat (h) tick();
      div_clk_in = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rise"}, rise_tick, 0);
    chk({tag, "_fall"}, fall_tick, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // Called right after a reset edge: 4-high/4-low divider, edge-exact lock timing.
  task automatic lock_seq();
    rst = 1'b0;
    for (int n = 0; n < 48; n++) begin
      div_clk_in = ((n % 8) < 4);
      tick();
      if (n + 1 == 3)  chk("first_rise_latency", rise_tick, 1);
      if (n + 1 == 4)  chk("first_rise_width", rise_tick, 0);
      if (n + 1 == 7)  chk("first_fall_latency", fall_tick, 1);
      if (n + 1 == 43) chk("lock_before_6th", locked, 0);
      if (n + 1 == 44) chk("lock_after_6th", locked, 1);
    end
    chk("seq_period", period, 8);
    chk("seq_high", high_time, 4);
    chk("model_period_pin", m_period, 8);
    chk("model_high_pin", m_high, 4);
  endtask

  initial begin
    int bh, bl;
    rst = 1'b1;
    div_clk_in = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    lock_seq();

    // 8/9 jitter within tolerance keeps lock; an 11 breaks it.
    for (int i = 0; i < 4; i++) begin
      wave(4, 4, 1);
      wave(4, 5, 1);
    end
    chk("jitter_locked", locked, 1);
    wave(5, 6, 1);
    wave(4, 4, 1);
    chk("p11_period", period, 11);
    chk("p11_unlocked", locked, 0);
    wave(4, 4, 6);
    chk("relock", locked, 1);

    // Step to period 16.
    wave(8, 8, 6);
    chk("p16_period", period, 16);
    chk("p16_locked", locked, 1);

    // Randomized periods with occasional base changes and jitter.
    bh = 4; bl = 4;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bh = $urandom_range(1, 7);
        bl = $urandom_range(1, 7);
      end
      wave(bh + $urandom_range(0, 1), bl, 1);
    end

    // Loss of signal and recovery.
    wave(4, 4, 8);
    chk("pre_timeout_locked", locked, 1);
    div_clk_in = 1'b0;
    repeat (300) tick();
    chk("timeout_set", timeout, 1);
    chk("timeout_unlocked", locked, 0);
    chk("timeout_period_hold", period, 8);
    chk("model_timeout_pin", phase, 3);
    wave(4, 4, 3);
    chk("timeout_clear", timeout, 0);

    // Reset while locked with the input high, then the full sequence again.
    wave(4, 4, 6);
    rst = 1'b1;
    div_clk_in = 1'b1;
    tick();
    check_zero("midreset");
    lock_seq();

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
